// File: rtl/operand_pair_streamer_pkg.sv
// Shared types and sizing helpers for the operand pair streamer and its chunk buffers.
package operand_pair_streamer_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ARMED   = 2'd1,
        STREAM  = 2'd2
    } streamer_state_t;

    function automatic int chunk_count(input int bits, input int reg_size);
        return bits / reg_size;
    endfunction

    // Wide enough to hold CHUNKS itself, so a count can express "full".
    function automatic int chunk_idx_width(input int chunks);
        return $clog2(chunks + 1);
    endfunction

    function automatic int chunk_addr_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/operand_pair_streamer_if.sv
// Chunk-stream bundle between operand producers, the streamer and the multiplier.
interface operand_pair_streamer_if #(
    parameter int REGISTER_SIZE = 32
);
    logic [REGISTER_SIZE-1:0] n_chunk_in;
    logic                     n_valid_in;
    logic                     n_ready_out;
    logic [REGISTER_SIZE-1:0] m_chunk_in;
    logic                     m_valid_in;
    logic                     m_ready_out;
    logic                     ready_in;
    logic [REGISTER_SIZE-1:0] n_out;
    logic [REGISTER_SIZE-1:0] m_out;
    logic                     valid_out;
    logic                     last_out;
    logic                     busy_out;

    modport master (
        output n_chunk_in, n_valid_in, m_chunk_in, m_valid_in, ready_in,
        input  n_ready_out, m_ready_out, n_out, m_out, valid_out, last_out, busy_out
    );

    modport slave (
        input  n_chunk_in, n_valid_in, m_chunk_in, m_valid_in, ready_in,
        output n_ready_out, m_ready_out, n_out, m_out, valid_out, last_out, busy_out
    );
endinterface

// File: rtl/operand_pair_streamer_chunk_buffer.sv
// Single-operand chunk store: sequential writes with fill counter, registered indexed read.
// Read data lands one cycle after rd_en_i; writes are dropped once full until clr_i.
module chunk_buffer
    import operand_pair_streamer_pkg::*;
#(
    parameter int W      = 32,
    parameter int CHUNKS = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               wr_en_i,
    input  logic [W-1:0]                       wr_dat_i,
    input  logic                               clr_i,
    input  logic                               rd_en_i,
    input  logic [chunk_addr_width(CHUNKS)-1:0] rd_addr_i,
    output logic                               full_o,
    output logic [W-1:0]                       rd_dat_o
);
    localparam int IDX_W  = chunk_idx_width(CHUNKS);
    localparam int ADDR_W = chunk_addr_width(CHUNKS);

    logic [W-1:0]     mem_q [CHUNKS];
    logic [IDX_W-1:0] wcnt_q, wcnt_d;
    logic [W-1:0]     rd_dat_q;
    logic             wr_ok;

    assign full_o   = (wcnt_q == IDX_W'(CHUNKS));
    assign wr_ok    = wr_en_i && !full_o;
    assign rd_dat_o = rd_dat_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (clr_i) begin
            wcnt_d = '0;
        end else if (wr_ok) begin
            wcnt_d = wcnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q   <= '0;
            rd_dat_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            if (rd_en_i) begin
                rd_dat_q <= mem_q[rd_addr_i];
            end
        end
    end

    // Storage is not reset: contents are only read after a full fill.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wcnt_q[ADDR_W-1:0]] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/operand_pair_streamer.sv
// Buffers operands N and M, then replays them in lockstep, LS chunk first, one pair per cycle.
// First pair one cycle after ready_in is seen in ARMED; both input sides stall while armed/streaming.
module operand_pair_streamer
    import operand_pair_streamer_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 2048
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    operand_pair_streamer_if.slave  bus
);
    localparam int CHUNKS = chunk_count(BITS_IN_NUM, REGISTER_SIZE);
    localparam int IDX_W  = chunk_idx_width(CHUNKS);
    localparam int ADDR_W = chunk_addr_width(CHUNKS);

    streamer_state_t   state_q, state_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              rd_en, clr;
    logic [ADDR_W-1:0] rd_addr;
    logic              n_full, m_full;
    logic              n_wr, m_wr;

    assign bus.n_ready_out = (state_q == COLLECT) && !n_full;
    assign bus.m_ready_out = (state_q == COLLECT) && !m_full;
    assign n_wr            = bus.n_valid_in && bus.n_ready_out;
    assign m_wr            = bus.m_valid_in && bus.m_ready_out;
    assign bus.valid_out   = valid_q;
    assign bus.last_out    = last_q;
    assign bus.busy_out    = busy_q;

    chunk_buffer #(.W(REGISTER_SIZE), .CHUNKS(CHUNKS)) u_n_buf (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .wr_en_i  (n_wr),
        .wr_dat_i (bus.n_chunk_in),
        .clr_i    (clr),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .full_o   (n_full),
        .rd_dat_o (bus.n_out)
    );

    chunk_buffer #(.W(REGISTER_SIZE), .CHUNKS(CHUNKS)) u_m_buf (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .wr_en_i  (m_wr),
        .wr_dat_i (bus.m_chunk_in),
        .clr_i    (clr),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .full_o   (m_full),
        .rd_dat_o (bus.m_out)
    );

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        clr      = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (n_full && m_full) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (bus.ready_in) begin
                    rd_en    = 1'b1;
                    valid_d  = 1'b1;
                    last_d   = (CHUNKS == 1);
                    rd_idx_d = IDX_W'(1);
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                // The multiplier drops ready while consuming, so ready_in is not consulted here.
                if (rd_idx_q == IDX_W'(CHUNKS)) begin
                    clr      = 1'b1;
                    rd_idx_d = '0;
                    state_d  = COLLECT;
                end else begin
                    rd_en    = 1'b1;
                    rd_addr  = rd_idx_q[ADDR_W-1:0];
                    valid_d  = 1'b1;
                    last_d   = (rd_idx_q == IDX_W'(CHUNKS - 1));
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
        busy_d = (state_d != COLLECT);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= COLLECT;
            rd_idx_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_operand_pair_streamer.sv
// Directed bench for operand_pair_streamer with a pair/product scoreboard fed by the stimulus.
module tb_operand_pair_streamer;
    localparam int RS   = 8;
    localparam int BITS = 32;
    localparam int CH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_pair_streamer_if #(.REGISTER_SIZE(RS)) bus ();

    operand_pair_streamer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BITS)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] n;
        logic [7:0] m;
        logic       last;
    } pair_t;

    pair_t       exp_q[$];
    logic [63:0] prod_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_op(input logic [31:0] nv, input logic [31:0] mv);
        for (int i = 0; i < CH; i++) begin
            exp_q.push_back(pair_t'{n: nv[8*i +: 8], m: mv[8*i +: 8], last: (i == CH - 1)});
        end
        prod_q.push_back({32'd0, nv} * {32'd0, mv});
    endtask

    task automatic beat(input logic nv, input logic [7:0] nd, input logic mv, input logic [7:0] md);
        @(negedge clk);
        bus.n_valid_in = nv;
        bus.n_chunk_in = nd;
        bus.m_valid_in = mv;
        bus.m_chunk_in = md;
    endtask

    // Holds each side's current chunk until accepted; sync_last pairs the final beats.
    task automatic fill(input logic [31:0] nv, input logic [31:0] mv, input bit gaps, input bit sync_last);
        int ni = 0;
        int mi = 0;
        int t  = 0;
        bit rn;
        bit rm;
        expect_op(nv, mv);
        while ((ni < CH || mi < CH) && t < 400) begin
            @(negedge clk);
            rn = !gaps || ($urandom_range(0, 1) == 1);
            rm = !gaps || ($urandom_range(0, 1) == 1);
            bus.n_valid_in = (ni < CH) && ((sync_last && ni == CH - 1) ? (mi == CH - 1) : rn);
            bus.m_valid_in = (mi < CH) && ((sync_last && mi == CH - 1) ? (ni == CH - 1) : rm);
            bus.n_chunk_in = nv[8*(ni % CH) +: 8];
            bus.m_chunk_in = mv[8*(mi % CH) +: 8];
            if (bus.n_valid_in && bus.n_ready_out) ni++;
            if (bus.m_valid_in && bus.m_ready_out) mi++;
            t++;
        end
        check("fill_done", 64'((ni == CH) && (mi == CH)), 64'(1));
        @(negedge clk);
        bus.n_valid_in = 1'b0;
        bus.m_valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((bus.busy_out || bus.valid_out || exp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(t < 100), 64'(1));
    endtask

    // Output monitor: scoreboard compare, contiguity, and reassembled product check.
    logic [31:0] n_acc = '0;
    logic [31:0] m_acc = '0;
    int          k = 0;
    bit          prev_open = 1'b0;

    always @(negedge clk) begin
        pair_t e;
        if (rst) begin
            prev_open = 1'b0;
            k = 0;
        end else begin
            if (prev_open) check("contiguous", 64'(bus.valid_out), 64'(1));
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(bus.valid_out), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("n_out", 64'(bus.n_out), 64'(e.n));
                    check("m_out", 64'(bus.m_out), 64'(e.m));
                    check("last_out", 64'(bus.last_out), 64'(e.last));
                end
                if (k < CH) begin
                    n_acc[8*k +: 8] = bus.n_out;
                    m_acc[8*k +: 8] = bus.m_out;
                end
                k++;
                if (bus.last_out) begin
                    if (prod_q.size() == 0) check("spurious_last", 64'(bus.last_out), 64'(0));
                    else check("product", {32'd0, n_acc} * {32'd0, m_acc}, prod_q.pop_front());
                    k = 0;
                end
                prev_open = !bus.last_out;
            end else begin
                prev_open = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nv;
        logic [31:0] mv;
        int t;
        bus.n_valid_in = 1'b0;
        bus.m_valid_in = 1'b0;
        bus.n_chunk_in = '0;
        bus.m_chunk_in = '0;
        bus.ready_in   = 1'b0;

        // Reset values
        #12;
        check("rst_valid", 64'(bus.valid_out), 64'(0));
        check("rst_last", 64'(bus.last_out), 64'(0));
        check("rst_n_out", 64'(bus.n_out), 64'(0));
        check("rst_m_out", 64'(bus.m_out), 64'(0));
        check("rst_busy", 64'(bus.busy_out), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_n_ready", 64'(bus.n_ready_out), 64'(1));
        check("post_rst_m_ready", 64'(bus.m_ready_out), 64'(1));

        // 1: N fully, then M, ready_in high
        bus.ready_in = 1'b1;
        nv = 32'h01020304;
        mv = 32'h11121314;
        expect_op(nv, mv);
        for (int i = 0; i < CH; i++) beat(1'b1, nv[8*i +: 8], 1'b0, 8'h00);
        for (int i = 0; i < CH; i++) beat(1'b0, 8'h00, 1'b1, mv[8*i +: 8]);
        beat(1'b0, 8'h00, 1'b0, 8'h00);
        check("s1_full_n_ready", 64'(bus.n_ready_out), 64'(0));
        check("s1_full_m_ready", 64'(bus.m_ready_out), 64'(0));
        @(negedge clk);
        check("s1_armed_busy", 64'(bus.busy_out), 64'(1));
        check("s1_armed_valid", 64'(bus.valid_out), 64'(0));
        @(negedge clk);
        check("s1_first_valid", 64'(bus.valid_out), 64'(1));
        wait_drain();
        check("s1_hold_n", 64'(bus.n_out), 64'(8'h01));
        check("s1_hold_m", 64'(bus.m_out), 64'(8'h11));
        check("s1_busy_drop", 64'(bus.busy_out), 64'(0));
        check("s1_n_ready_back", 64'(bus.n_ready_out), 64'(1));

        // 2: interleaved with gaps, last beats in the same cycle
        fill(nv, mv, 1'b1, 1'b1);
        check("s2_full_n_ready", 64'(bus.n_ready_out), 64'(0));
        check("s2_full_m_ready", 64'(bus.m_ready_out), 64'(0));
        @(negedge clk);
        check("s2_armed_busy", 64'(bus.busy_out), 64'(1));
        @(negedge clk);
        check("s2_first_valid", 64'(bus.valid_out), 64'(1));
        wait_drain();

        // 3: N full, M partial; extra N beat is refused
        nv = 32'hA1B2C3D4;
        mv = 32'h55667788;
        expect_op(nv, mv);
        for (int i = 0; i < CH; i++) beat(1'b1, nv[8*i +: 8], (i < 2), mv[8*i +: 8]);
        for (int r = 0; r < 4; r++) begin
            beat(1'b1, 8'hAA, 1'b0, 8'h00);
            check("s3_n_ready", 64'(bus.n_ready_out), 64'(0));
            check("s3_m_ready", 64'(bus.m_ready_out), 64'(1));
            check("s3_no_valid", 64'(bus.valid_out), 64'(0));
        end
        check("s3_not_busy", 64'(bus.busy_out), 64'(0));
        beat(1'b0, 8'h00, 1'b1, mv[23:16]);
        beat(1'b0, 8'h00, 1'b1, mv[31:24]);
        beat(1'b0, 8'h00, 1'b0, 8'h00);
        wait_drain();

        // 4: armed with ready_in low, then a one-cycle ready pulse
        bus.ready_in = 1'b0;
        nv = 32'h0F1E2D3C;
        mv = 32'hF0E1D2C3;
        fill(nv, mv, 1'b0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            check("s4_hold_valid", 64'(bus.valid_out), 64'(0));
            check("s4_hold_busy", 64'(bus.busy_out), 64'(1));
        end
        @(negedge clk);
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.ready_in = 1'b0;
        check("s4_first_valid", 64'(bus.valid_out), 64'(1));
        wait_drain();

        // 5: async reset during the second pair
        bus.ready_in = 1'b1;
        nv = 32'h99887766;
        mv = 32'h44332211;
        fill(nv, mv, 1'b0, 1'b0);
        t = 0;
        while (!bus.valid_out && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("s5_stream_start", 64'(bus.valid_out), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("s5_rst_valid", 64'(bus.valid_out), 64'(0));
        check("s5_rst_last", 64'(bus.last_out), 64'(0));
        check("s5_rst_busy", 64'(bus.busy_out), 64'(0));
        check("s5_rst_n_out", 64'(bus.n_out), 64'(0));
        exp_q.delete();
        prod_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("s5_n_ready", 64'(bus.n_ready_out), 64'(1));
        check("s5_m_ready", 64'(bus.m_ready_out), 64'(1));
        nv = 32'h13579BDF;
        mv = 32'h2468ACE0;
        fill(nv, mv, 1'b1, 1'b0);
        wait_drain();

        // 6: three back-to-back operand pairs, products against the reference
        for (int p = 0; p < 3; p++) begin
            nv = $urandom;
            mv = $urandom;
            fill(nv, mv, 1'b0, 1'b0);
        end
        wait_drain();
        check("s6_products_drained", 64'(prod_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
